// File: rtl/pipelined_adder_tree.sv
// Pipelined N-channel unsigned adder tree with valid/ready flow control.
// Define ADDER_TREE_SATURATE_EN to clamp out_sum instead of wrapping.
module pipelined_adder_tree #(
   parameter int N = 8,
   parameter int W = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N*W-1:0] in_data,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [W-1:0]   out_sum,
   output logic           out_ovf
);

   localparam int L = $clog2(N);

   logic           w_stall;
   logic [W+L-1:0] w_exact;

   for (genvar k = 1; k <= L; k++) begin : g_lvl
      localparam int CW = W + k;
      localparam int CN = N >> k;

      logic [2*CN*(CW-1)-1:0] w_src;
      logic                   w_vin;
      logic [CN*CW-1:0]       r_sum;
      logic                   r_vld;

      if (k == 1) begin : g_first
         assign w_src = in_data;
         assign w_vin = in_valid;
      end else begin : g_next
         assign w_src = g_lvl[k-1].r_sum;
         assign w_vin = g_lvl[k-1].r_vld;
      end

      // Each level widens by one bit so no carry is ever lost.
      always_ff @(posedge clk) begin
         if (rst) begin
            r_vld <= 1'b0;
            r_sum <= '0;
         end else if (!w_stall) begin
            r_vld <= w_vin;
            for (int j = 0; j < CN; j++) begin
               r_sum[j*CW +: CW] <=
                  CW'(w_src[2*j*(CW-1) +: CW-1]) +
                  CW'(w_src[(2*j+1)*(CW-1) +: CW-1]);
            end
         end
      end
   end

   assign w_exact   = g_lvl[L].r_sum;
   assign out_valid = g_lvl[L].r_vld;
   assign w_stall   = out_valid && !out_ready;
   assign in_ready  = !w_stall;
   assign out_ovf   = |w_exact[W+L-1:W];

`ifdef ADDER_TREE_SATURATE_EN
   assign out_sum = out_ovf ? '1 : w_exact[W-1:0];
`else
   assign out_sum = w_exact[W-1:0];
`endif

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Self-checking bench for pipelined_adder_tree (N=4 and N=8, W=8).
// Expected sums come from plain arithmetic on the applied operands.
module tb_pipelined_adder_tree;

   logic        clk = 1'b0;
   logic        rst;
   logic        v4, r4, ir4, ov4, of4;
   logic [31:0] d4;
   logic [7:0]  os4;
   logic        v8, r8, ir8, ov8, of8;
   logic [63:0] d8;
   logic [7:0]  os8;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   pipelined_adder_tree #(.N(4), .W(8)) u_dut4 (
      .clk(clk), .rst(rst),
      .in_valid(v4), .in_ready(ir4), .in_data(d4),
      .out_valid(ov4), .out_ready(r4),
      .out_sum(os4), .out_ovf(of4)
   );

   pipelined_adder_tree #(.N(8), .W(8)) u_dut8 (
      .clk(clk), .rst(rst),
      .in_valid(v8), .in_ready(ir8), .in_data(d8),
      .out_valid(ov8), .out_ready(r8),
      .out_sum(os8), .out_ovf(of8)
   );

   function automatic int exact4(input logic [31:0] d);
      int s;
      s = 0;
      for (int i = 0; i < 4; i++) s += int'(d[i*8 +: 8]);
      return s;
   endfunction

   function automatic int exact8(input logic [63:0] d);
      int s;
      s = 0;
      for (int i = 0; i < 8; i++) s += int'(d[i*8 +: 8]);
      return s;
   endfunction

   function automatic logic [7:0] red(input int e);
`ifdef ADDER_TREE_SATURATE_EN
      if (e > 255) return 8'hFF;
`endif
      return e[7:0];
   endfunction

   task automatic idle(input int n);
      v4 = 1'b0; v8 = 1'b0; r4 = 1'b1; r8 = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      v4 = 1'b0; v8 = 1'b0; r4 = 1'b1; r8 = 1'b1;
      d4 = '0; d8 = '0;
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if (ov4 !== 1'b0 || os4 !== 8'd0 || of4 !== 1'b0 || ir4 !== 1'b1) begin
         n_fail++;
         $display("FAIL reset4: v=%b s=%0d o=%b rdy=%b, want 0/0/0/1",
                  ov4, os4, of4, ir4);
      end
      n_tests++;
      if (ov8 !== 1'b0 || os8 !== 8'd0 || of8 !== 1'b0 || ir8 !== 1'b1) begin
         n_fail++;
         $display("FAIL reset8: v=%b s=%0d o=%b rdy=%b, want 0/0/0/1",
                  ov8, os8, of8, ir8);
      end
      rst = 1'b0;
   endtask

   task automatic test_back_to_back();
      r4 = 1'b1;
      v4 = 1'b1;
      d4 = {8'd9, 8'd11, 8'd5, 8'd4};
      @(posedge clk); #1;
      n_tests++;
      if (ov4 !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_early: valid=%b, want 0", ov4);
      end
      d4 = {8'd7, 8'd200, 8'd3, 8'd15};
      @(posedge clk); #1;
      v4 = 1'b0;
      d4 = $urandom();
      n_tests++;
      if (ov4 !== 1'b1 || os4 !== 8'd29 || of4 !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_first: v=%b s=%0d o=%b, want 1/29/0",
                  ov4, os4, of4);
      end
      @(posedge clk); #1;
      n_tests++;
      if (ov4 !== 1'b1 || os4 !== 8'd225 || of4 !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_second: v=%b s=%0d o=%b, want 1/225/0",
                  ov4, os4, of4);
      end
      @(posedge clk); #1;
      n_tests++;
      if (ov4 !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_drain: valid=%b, want 0", ov4);
      end
   endtask

   task automatic test_overflow4();
      int e;
      r4 = 1'b1;
      v4 = 1'b1;
      d4 = {8'd0, 8'd0, 8'd100, 8'd200};
      e = exact4(d4);
      @(posedge clk); #1;
      v4 = 1'b0;
      d4 = $urandom();
      @(posedge clk); #1;
      n_tests++;
      if (ov4 !== 1'b1 || os4 !== red(e) || of4 !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf4: v=%b s=%0d o=%b, want 1/%0d/1",
                  ov4, os4, of4, red(e));
      end
   endtask

   task automatic test_all_ones8();
      int e;
      r8 = 1'b1;
      v8 = 1'b1;
      d8 = '1;
      e = exact8(d8);
      @(posedge clk); #1;
      v8 = 1'b0;
      d8 = {$urandom(), $urandom()};
      @(posedge clk); #1;
      n_tests++;
      if (ov8 !== 1'b0) begin
         n_fail++;
         $display("FAIL ones8_early: valid=%b, want 0", ov8);
      end
      @(posedge clk); #1;
      n_tests++;
      if (ov8 !== 1'b1 || os8 !== red(e) || of8 !== 1'b1) begin
         n_fail++;
         $display("FAIL ones8: v=%b s=%0d o=%b, want 1/%0d/1",
                  ov8, os8, of8, red(e));
      end
   endtask

   task automatic test_valid_pattern(input bit alt);
      bit vin[32];
      int ein[32];
      bit ev;
      r8 = 1'b1;
      for (int s = 0; s < 30; s++) begin
         vin[s] = 1'b0;
         if (s < 24) vin[s] = alt ? (s % 2 == 0) : 1'($urandom_range(0, 1));
         d8 = {$urandom(), $urandom()};
         ein[s] = exact8(d8);
         v8 = vin[s];
         @(posedge clk); #1;
         ev = (s >= 2) ? vin[s-2] : 1'b0;
         n_tests++;
         if (ov8 !== ev) begin
            n_fail++;
            $display("FAIL pattern_valid[%0d]: got %b, want %b", s, ov8, ev);
         end
         if (ev) begin
            n_tests++;
            if (os8 !== red(ein[s-2]) || of8 !== (ein[s-2] > 255)) begin
               n_fail++;
               $display("FAIL pattern_sum[%0d]: s=%0d o=%b, want %0d/%b",
                        s, os8, of8, red(ein[s-2]), ein[s-2] > 255);
            end
         end
      end
   endtask

   task automatic test_stall();
      int q[$];
      int sent;
      int got;
      bit exp_rdy;
      sent = 0;
      got  = 0;
      for (int c = 0; c < 60 && got < 6; c++) begin
         v8 = (sent < 6);
         d8 = {$urandom(), $urandom()};
         r8 = !(c >= 5 && c < 9);
         #1;
         exp_rdy = !(ov8 && !r8);
         n_tests++;
         if (ir8 !== exp_rdy) begin
            n_fail++;
            $display("FAIL stall_rdy[%0d]: got %b, want %b", c, ir8, exp_rdy);
         end
         if (ov8) begin
            n_tests++;
            if (q.size() == 0) begin
               n_fail++;
               $display("FAIL stall_extra[%0d]: got sum %0d, want none",
                        c, os8);
            end else if (os8 !== red(q[0]) || of8 !== (q[0] > 255)) begin
               n_fail++;
               $display("FAIL stall_sum[%0d]: s=%0d o=%b, want %0d/%b",
                        c, os8, of8, red(q[0]), q[0] > 255);
            end
         end
         if (ov8 && r8) begin
            if (q.size() > 0) void'(q.pop_front());
            got++;
         end
         if (v8 && exp_rdy) begin
            q.push_back(exact8(d8));
            sent++;
         end
         @(posedge clk); #1;
      end
      v8 = 1'b0;
      r8 = 1'b1;
      n_tests++;
      if (got != 6 || sent != 6 || q.size() != 0) begin
         n_fail++;
         $display("FAIL stall_count: got=%0d sent=%0d left=%0d, want 6/6/0",
                  got, sent, q.size());
      end
      repeat (4) begin
         @(posedge clk); #1;
         n_tests++;
         if (ov8 !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_dup: valid=%b, want 0", ov8);
         end
      end
   endtask

   task automatic test_reset_midflight();
      r4 = 1'b1;
      v4 = 1'b1;
      d4 = {8'd7, 8'd7, 8'd7, 8'd7};
      @(posedge clk); #1;
      d4 = {8'd1, 8'd1, 8'd1, 8'd1};
      @(posedge clk); #1;
      rst = 1'b1;
      d4 = $urandom();
      @(posedge clk); #1;
      n_tests++;
      if (ov4 !== 1'b0 || os4 !== 8'd0 || of4 !== 1'b0 || ir4 !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst: v=%b s=%0d o=%b rdy=%b, want 0/0/0/1",
                  ov4, os4, of4, ir4);
      end
      rst = 1'b0;
      v4  = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         n_tests++;
         if (ov4 !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_ghost: valid=%b s=%0d, want 0", ov4, os4);
         end
      end
      v4 = 1'b1;
      d4 = {8'd4, 8'd3, 8'd2, 8'd1};
      @(posedge clk); #1;
      v4 = 1'b0;
      d4 = $urandom();
      @(posedge clk); #1;
      n_tests++;
      if (ov4 !== 1'b1 || os4 !== 8'd10 || of4 !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_fresh: v=%b s=%0d o=%b, want 1/10/0",
                  ov4, os4, of4);
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      idle(3);
      test_overflow4();
      idle(3);
      test_all_ones8();
      idle(4);
      test_valid_pattern(1'b1);
      test_valid_pattern(1'b0);
      idle(4);
      test_stall();
      test_reset_midflight();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
